// File: rtl/out_trace_buffer_pkg.sv
// Shared constants and helpers for the CPU result trace buffer.
// Holds the default geometry and the saturating drop-counter arithmetic.
package out_trace_buffer_pkg;

   localparam int TRACE_DATA_WIDTH = 32;
   localparam int TRACE_DEPTH      = 8;
   localparam int TRACE_ADDR_WIDTH = 3;
   localparam int DROP_CNT_WIDTH   = 8;

   typedef logic [DROP_CNT_WIDTH-1:0] drop_cnt_t;

   localparam drop_cnt_t DROP_CNT_MAX = 8'd255;

   function automatic drop_cnt_t drop_cnt_inc(input drop_cnt_t value);
      return (value == DROP_CNT_MAX) ? value : value + 1'b1;
   endfunction

endpackage

// File: rtl/out_trace_buffer_if.sv
// Trace buffer bus: sampled CPU result in, valid/ready drain and status out.
// The master side is the producer/consumer environment, the slave side is the buffer.
interface out_trace_buffer_if
   import out_trace_buffer_pkg::*;
#(
   parameter int DATA_WIDTH = TRACE_DATA_WIDTH,
   parameter int ADDR_WIDTH = TRACE_ADDR_WIDTH
);

   logic [DATA_WIDTH-1:0] out_in;
   logic                  capture_en;
   logic                  clear;
   logic [DATA_WIDTH-1:0] trace_data;
   logic                  trace_valid;
   logic                  trace_ready;
   logic [ADDR_WIDTH:0]   count;
   logic                  overflow;
   drop_cnt_t             drop_count;

   modport master (
      output out_in, capture_en, clear, trace_ready,
      input  trace_data, trace_valid, count, overflow, drop_count
   );

   modport slave (
      input  out_in, capture_en, clear, trace_ready,
      output trace_data, trace_valid, count, overflow, drop_count
   );

endinterface

// File: rtl/out_trace_buffer_sync_fifo.sv
// First-word fall-through synchronous FIFO with a registered head word.
// Clear flushes occupancy but leaves the head register holding its last value.
module sync_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_clear,
   input  logic                  i_push,
   input  logic                  i_pop,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_full,
   output logic                  o_empty,
   output logic [ADDR_WIDTH:0]   o_count
);

   localparam logic [ADDR_WIDTH:0] LP_FULL = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] LP_ONE  = (ADDR_WIDTH + 1)'(1);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic [DATA_WIDTH-1:0] r_head;
   logic [ADDR_WIDTH-1:0] w_rd_next;
   logic                  w_pop;
   logic                  w_push;

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_pop     = i_pop && (r_count != '0) && !i_clear;
   assign w_push    = i_push && ((r_count != LP_FULL) || w_pop) && !i_clear;
   assign w_rd_next = r_rd_ptr + 1'b1;

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // The head register is loaded from the incoming word when it becomes the
   // only entry, otherwise from the slot behind the one being popped.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         r_head   <= '0;
      end else if (i_clear) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= w_rd_next;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_push && ((r_count == '0) || ((r_count == LP_ONE) && w_pop))) begin
            r_head <= i_data;
         end else if (w_pop && (r_count > LP_ONE)) begin
            r_head <= r_mem[w_rd_next];
         end
      end
   end

   assign o_data  = r_head;
   assign o_full  = (r_count == LP_FULL);
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

endmodule

// File: rtl/out_trace_buffer.sv
// Traces the CPU result bus into a small FIFO, optionally keeping only changes,
// and counts samples dropped while the consumer stalls.
module out_trace_buffer
   import out_trace_buffer_pkg::*;
#(
   parameter int DATA_WIDTH  = TRACE_DATA_WIDTH,
   parameter int DEPTH       = TRACE_DEPTH,
   parameter int ADDR_WIDTH  = TRACE_ADDR_WIDTH,
   parameter bit CHANGE_ONLY = 1'b1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   out_trace_buffer_if.slave trace_bus
);

   logic [DATA_WIDTH-1:0] r_last;
   logic                  r_first;
   logic                  r_overflow;
   drop_cnt_t             r_drop_count;

   logic                  w_req;
   logic                  w_pop;
   logic                  w_drop;
   logic                  w_full;
   logic                  w_empty;
   logic [DATA_WIDTH-1:0] w_head;
   logic [ADDR_WIDTH:0]   w_count;

   // The first enabled sample after reset or clear always counts as a change.
   assign w_req  = trace_bus.capture_en &&
                   (!CHANGE_ONLY || r_first || (trace_bus.out_in != r_last));
   assign w_pop  = !w_empty && trace_bus.trace_ready;
   assign w_drop = w_req && w_full && !w_pop && !trace_bus.clear;

   sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clear (trace_bus.clear),
      .i_push  (w_req),
      .i_pop   (w_pop),
      .i_data  (trace_bus.out_in),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // The last-value register tracks every enabled sample, including dropped ones.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_last       <= '0;
         r_first      <= 1'b1;
         r_overflow   <= 1'b0;
         r_drop_count <= '0;
      end else if (trace_bus.clear) begin
         r_first      <= 1'b1;
         r_overflow   <= 1'b0;
         r_drop_count <= '0;
      end else begin
         if (trace_bus.capture_en) begin
            r_last  <= trace_bus.out_in;
            r_first <= 1'b0;
         end
         if (w_drop) begin
            r_overflow   <= 1'b1;
            r_drop_count <= drop_cnt_inc(r_drop_count);
         end
      end
   end

   assign trace_bus.trace_data  = w_head;
   assign trace_bus.trace_valid = !w_empty;
   assign trace_bus.count       = w_count;
   assign trace_bus.overflow    = r_overflow;
   assign trace_bus.drop_count  = r_drop_count;

endmodule

// File: tb/tb_out_trace_buffer.sv
// Bench for out_trace_buffer: a change-only and an every-sample instance share
// one stimulus stream and are compared each cycle against a queue model.
module tb_out_trace_buffer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [31:0] sIn = '0;
   logic        sEn = 1'b0;
   logic        sClear = 1'b0;
   logic        sReady = 1'b0;

   int vectors = 0;
   int miscompares = 0;
   logic [31:0] drained[$];

   out_trace_buffer_if busChg ();
   out_trace_buffer_if busAll ();

   assign busChg.out_in      = sIn;
   assign busChg.capture_en  = sEn;
   assign busChg.clear       = sClear;
   assign busChg.trace_ready = sReady;
   assign busAll.out_in      = sIn;
   assign busAll.capture_en  = sEn;
   assign busAll.clear       = sClear;
   assign busAll.trace_ready = sReady;

   out_trace_buffer #(.CHANGE_ONLY(1'b1)) dutChg (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .trace_bus (busChg)
   );

   out_trace_buffer #(.CHANGE_ONLY(1'b0)) dutAll (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .trace_bus (busAll)
   );

   always #5 clk = ~clk;

   // Reference model: index 0 keeps only changed samples, index 1 keeps all.
   for (genvar g = 0; g < 2; g++) begin : g_model
      localparam bit CO = (g == 0);
      logic [31:0] q[$];
      logic [31:0] last = '0;
      logic [31:0] head = '0;
      bit          first = 1'b1;
      bit          ovf = 1'b0;
      int          drops = 0;
      bit          req;

      always @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            q.delete();
            last  = '0;
            head  = '0;
            first = 1'b1;
            ovf   = 1'b0;
            drops = 0;
         end else if (sClear) begin
            q.delete();
            first = 1'b1;
            ovf   = 1'b0;
            drops = 0;
         end else begin
            req = sEn && (!CO || first || (sIn != last));
            if (sEn) begin
               last  = sIn;
               first = 1'b0;
            end
            if ((q.size() > 0) && sReady) begin
               void'(q.pop_front());
            end
            if (req) begin
               if (q.size() < 8) begin
                  q.push_back(sIn);
               end else begin
                  ovf = 1'b1;
                  if (drops < 255) drops++;
               end
            end
            if (q.size() > 0) head = q[0];
         end
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Inputs change just after a rising edge; return once that cycle's edge has passed.
   task automatic applyStimulus(input logic [31:0] in, input logic en, input logic clr, input logic rdy);
      sIn    = in;
      sEn    = en;
      sClear = clr;
      sReady = rdy;
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      checkOutput("chg.count", 64'(busChg.count), 64'(g_model[0].q.size()));
      checkOutput("chg.valid", 64'(busChg.trace_valid), 64'(g_model[0].q.size() > 0));
      checkOutput("chg.data", 64'(busChg.trace_data), 64'(g_model[0].head));
      checkOutput("chg.overflow", 64'(busChg.overflow), 64'(g_model[0].ovf));
      checkOutput("chg.drops", 64'(busChg.drop_count), 64'(g_model[0].drops));
      checkOutput("all.count", 64'(busAll.count), 64'(g_model[1].q.size()));
      checkOutput("all.valid", 64'(busAll.trace_valid), 64'(g_model[1].q.size() > 0));
      checkOutput("all.data", 64'(busAll.trace_data), 64'(g_model[1].head));
      checkOutput("all.overflow", 64'(busAll.overflow), 64'(g_model[1].ovf));
      checkOutput("all.drops", 64'(busAll.drop_count), 64'(g_model[1].drops));
      if (busChg.trace_valid && sReady) drained.push_back(busChg.trace_data);
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [31:0] expDrain[$];

      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset.count", 64'(busChg.count), 64'd0);
      checkOutput("reset.valid", 64'(busChg.trace_valid), 64'd0);
      checkOutput("reset.data", 64'(busChg.trace_data), 64'd0);
      checkOutput("reset.overflow", 64'(busAll.overflow), 64'd0);
      checkOutput("reset.drops", 64'(busAll.drop_count), 64'd0);
      rst_n = 1'b1;
      applyStimulus(0, 1'b0, 1'b0, 1'b0);

      // Change-only filtering with a free-running consumer
      drained.delete();
      applyStimulus(5, 1'b1, 1'b0, 1'b1);
      checkOutput("latency.valid", 64'(busChg.trace_valid), 64'd1);
      checkOutput("latency.data", 64'(busChg.trace_data), 64'd5);
      applyStimulus(5, 1'b1, 1'b0, 1'b1);
      applyStimulus(7, 1'b1, 1'b0, 1'b1);
      applyStimulus(7, 1'b1, 1'b0, 1'b1);
      applyStimulus(7, 1'b1, 1'b0, 1'b1);
      applyStimulus(9, 1'b1, 1'b0, 1'b1);
      applyStimulus(9, 1'b0, 1'b0, 1'b1);
      applyStimulus(9, 1'b0, 1'b0, 1'b1);
      checkOutput("filter.n", 64'(drained.size()), 64'd3);
      expDrain = '{32'd5, 32'd7, 32'd9};
      for (int i = 0; i < 3; i++) begin
         checkOutput("filter.item", (i < drained.size()) ? 64'(drained[i]) : 64'hDEAD, 64'(expDrain[i]));
      end

      // Stalled consumer: ten distinct values into eight entries
      for (int i = 0; i < 10; i++) applyStimulus(32'(100 + i), 1'b1, 1'b0, 1'b0);
      checkOutput("stall.count", 64'(busChg.count), 64'd8);
      checkOutput("stall.overflow", 64'(busChg.overflow), 64'd1);
      checkOutput("stall.drops", 64'(busChg.drop_count), 64'd2);
      checkOutput("stall.head", 64'(busChg.trace_data), 64'd100);

      // Full with a simultaneous pop and push
      drained.delete();
      applyStimulus(200, 1'b1, 1'b0, 1'b1);
      checkOutput("fullpop.count", 64'(busChg.count), 64'd8);
      checkOutput("fullpop.drops", 64'(busChg.drop_count), 64'd2);
      checkOutput("fullpop.head", 64'(busChg.trace_data), 64'd101);
      for (int i = 0; i < 8; i++) applyStimulus(200, 1'b0, 1'b0, 1'b1);
      checkOutput("drain.valid", 64'(busChg.trace_valid), 64'd0);
      expDrain = '{32'd100, 32'd101, 32'd102, 32'd103, 32'd104, 32'd105, 32'd106, 32'd107, 32'd200};
      checkOutput("drain.n", 64'(drained.size()), 64'd9);
      for (int i = 0; i < 9; i++) begin
         checkOutput("drain.item", (i < drained.size()) ? 64'(drained[i]) : 64'hDEAD, 64'(expDrain[i]));
      end

      // Clear with four entries and a simultaneous request
      for (int i = 0; i < 4; i++) applyStimulus(32'(300 + i), 1'b1, 1'b0, 1'b0);
      checkOutput("clear.pre", 64'(busChg.count), 64'd4);
      applyStimulus(303, 1'b1, 1'b1, 1'b0);
      checkOutput("clear.count", 64'(busChg.count), 64'd0);
      checkOutput("clear.valid", 64'(busChg.trace_valid), 64'd0);
      checkOutput("clear.overflow", 64'(busChg.overflow), 64'd0);
      checkOutput("clear.drops", 64'(busChg.drop_count), 64'd0);
      applyStimulus(303, 1'b1, 1'b0, 1'b0);
      checkOutput("clear.first.count", 64'(busChg.count), 64'd1);
      checkOutput("clear.first.data", 64'(busChg.trace_data), 64'd303);

      // Asynchronous reset in the middle of a cycle with five entries
      for (int i = 0; i < 4; i++) applyStimulus(32'(400 + i), 1'b1, 1'b0, 1'b0);
      checkOutput("areset.pre", 64'(busChg.count), 64'd5);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("areset.count", 64'(busChg.count), 64'd0);
      checkOutput("areset.valid", 64'(busChg.trace_valid), 64'd0);
      checkOutput("areset.overflow", 64'(busChg.overflow), 64'd0);
      checkOutput("areset.drops", 64'(busChg.drop_count), 64'd0);
      checkOutput("areset.data", 64'(busAll.trace_data), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus(0, 1'b1, 1'b0, 1'b0);
      checkOutput("areset.zero.count", 64'(busChg.count), 64'd1);
      checkOutput("areset.zero.valid", 64'(busChg.trace_valid), 64'd1);

      // Long stall: drop counter saturation and a frozen head
      applyStimulus(0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 300; i++) applyStimulus(32'(1000 + i), 1'b1, 1'b0, 1'b0);
      checkOutput("sat.count", 64'(busAll.count), 64'd8);
      checkOutput("sat.drops", 64'(busAll.drop_count), 64'd255);
      checkOutput("sat.head", 64'(busAll.trace_data), 64'd1000);
      checkOutput("sat.chg.drops", 64'(busChg.drop_count), 64'd255);
      applyStimulus(0, 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/out_trace_buffer.md
Name: out_trace_buffer

Overview:
- Downstream consumer of the CPU top-level result bus (the ALU output driven onto CPU Out).
- Samples the result each cycle, optionally keeps only changed values, and buffers them in a small FIFO.
- Presents the buffered values on a valid/ready drain port for a display, UART or testbench monitor, so results are not lost while the consumer stalls.

Parameters:
- DATA_WIDTH, 32, width of the sampled result and of the drain data.
- DEPTH, 8, FIFO entries; must be a power of two, minimum 2.
- ADDR_WIDTH, 3, log2(DEPTH).
- CHANGE_ONLY, 1:
  - 1: push only when the sample differs from the last sampled value.
  - 0: push on every enabled cycle.

Ports:
- Clk  input  1  system clock; all state changes on rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Out_in  input  DATA_WIDTH  CPU result bus being traced.
- Capture_en  input  1  sampling enable; no push when low.
- Clear  input  1  synchronous flush of FIFO and status.
- Trace_data  output  DATA_WIDTH  head-of-FIFO value (first-word fall-through).
- Trace_valid  output  1  high when FIFO not empty.
- Trace_ready  input  1  consumer accepts Trace_data when high with Trace_valid.
- Count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- Overflow  output  1  sticky: at least one sample dropped since reset/Clear.
- Drop_count  output  8  number of dropped samples, saturating at 255.

Behaviour:
- Reset (Reset low, asynchronous): all of the following take effect immediately, independent of Clk.
  - Pointers, Count, Overflow, Drop_count and the last-value register go to 0.
  - first flag goes to 1.
  - Trace_valid goes to 0 and Trace_data goes to 0.
  - FIFO storage contents are don't-care.
- Reset mid-operation: any pending or in-flight push or pop is lost. There is no partial state.
- Push request, evaluated each cycle:
  - req = Capture_en && (CHANGE_ONLY==0 || first || Out_in != last).
  - Whenever Capture_en is high: last <= Out_in and first <= 0. This happens even if the push is dropped.
- Pop: pop = Trace_valid && Trace_ready.
- Accept:
  - A push is written if req && (Count < DEPTH || pop).
  - Full with simultaneous pop: both happen and Count is unchanged.
- Drop: req && Count==DEPTH && !pop.
  - Sample discarded.
  - Overflow <= 1.
  - Drop_count increments unless already 255.
- Empty with simultaneous req: the push is accepted. There is no pop because Trace_valid was 0. No bypass: data is never passed combinationally from Out_in to Trace_data.
- Latency: a value sampled at rising edge N is visible on Trace_data with Trace_valid high immediately after edge N, provided the FIFO was empty.
- Ordering: strict FIFO order.
- Pointers: wrap modulo DEPTH. Count = pushes − pops, kept in a separate register.
- Trace_data holds its value while Trace_valid && !Trace_ready. It must not change until popped.
- Trace_data when empty: holds the last head value (don't-care to the consumer). It is 0 only after reset.
- Clear (synchronous, highest priority after reset):
  - Pointers, Count, Overflow and Drop_count go to 0; first goes to 1.
  - A push or pop in the same cycle is ignored.
  - last is not updated in a Clear cycle.
- Status outputs (Trace_valid, Count, Overflow, Drop_count) are registered; no combinational path from inputs.

Decomposition:
- Shared package holds:
  - DATA_WIDTH default;
  - TRACE_DEPTH and TRACE_ADDR_WIDTH constants;
  - DROP_CNT_WIDTH = 8 and DROP_CNT_MAX = 255.
- One sub-module is natural: sync_fifo (parameterised DATA_WIDTH/DEPTH, push/pop/full/empty/count, first-word fall-through, same Clk/Reset).
- out_trace_buffer wraps sync_fifo with the change-detect, drop and status logic.

Test Plan:
- Reset low mid-stream with Count=5 -> Count=0, Trace_valid=0, Overflow=0, Drop_count=0 asynchronously. First enabled sample after release is pushed even if it equals 0.
- CHANGE_ONLY=1, Out_in sequence 5,5,7,7,7,9 with Capture_en=1, Trace_ready=1 -> drain sees exactly 5,7,9, each one cycle after its first sample edge.
- Trace_ready=0, 10 distinct values pushed -> Count=8, Overflow=1, Drop_count=2. Then drain with Trace_ready=1 -> first 8 values in order, then Trace_valid=0.
- FIFO full (Count=8) and a new distinct value with Trace_ready=1 in the same cycle -> head popped, new value accepted, Count stays 8, Drop_count unchanged.
- Clear asserted with Count=4 and a simultaneous req -> next cycle Count=0, Overflow=0, Drop_count=0, no entry written. Following sample is pushed (first=1).
- CHANGE_ONLY=0, 300 pushes with Trace_ready=0 -> Count=8, Drop_count saturates at 255. Trace_data holds the first pushed value throughout.
